// File: rtl/ysyx_25040111_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25040111_mem_arb
// Brief    : Two-requester arbiter/sequencer for the single LSU memory port.
//            Grants the I-cache refill path or the data path, drives a
//            one-cycle start pulse with registered request fields, counts
//            I-side burst beats, routes beats to the owner, and aborts
//            transactions that stall for 2^TMO_W-1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25040111_mem_arb #(
  parameter int TMO_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  // I-side (instruction-cache refill)
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  output logic        i_ok,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // D-side (load/store)
  input  logic        d_req,
  input  logic        d_wen,
  input  logic        d_sign,
  input  logic [1:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ok,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // LSU master side
  output logic        m_start,
  output logic        m_wen,
  output logic        m_ren,
  output logic        m_sign,
  output logic [1:0]  m_mask,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [7:0]  m_tlen,
  input  logic [31:0] m_rdata,
  input  logic        m_valid,
  // Current owner, one-hot
  output logic [1:0]  gnt
);

  // State codes double as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_I = 2'b01,
    ST_OWN_D = 2'b10
  } state_t;

  localparam logic [TMO_W-1:0] c_wd_one = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_last_d;   // 1: D was served last, so I wins a tie
  logic             r_start;
  logic             r_wen;
  logic             r_ren;
  logic             r_sign;
  logic [1:0]       r_mask;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [7:0]       r_tlen;
  logic [7:0]       r_left;     // beats still to come after the current one
  logic [TMO_W-1:0] r_wd;

  logic w_own_i;
  logic w_own_d;
  logic w_wd_full;
  logic w_pick_i;
  logic w_pick_d;

  assign w_own_i   = (r_state == ST_OWN_I);
  assign w_own_d   = (r_state == ST_OWN_D);
  assign w_wd_full = &r_wd;

  // Round-robin tie break: the side not served last wins.
  assign w_pick_i = i_req & (~d_req | r_last_d);
  assign w_pick_d = d_req & ~w_pick_i;

  // Sequencer: grant in IDLE, count beats and watchdog while owned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b1;
      r_start  <= 1'b0;
      r_wen    <= 1'b0;
      r_ren    <= 1'b0;
      r_sign   <= 1'b0;
      r_mask   <= 2'b00;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_tlen   <= 8'd0;
      r_left   <= 8'd0;
      r_wd     <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_i) begin
            r_state <= ST_OWN_I;
            r_start <= 1'b1;
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
            r_sign  <= 1'b0;
            r_mask  <= 2'b11;
            r_addr  <= i_addr;
            r_wdata <= 32'd0;
            r_tlen  <= i_len;
            r_left  <= i_len;
            r_wd    <= '0;
          end else if (w_pick_d) begin
            r_state <= ST_OWN_D;
            r_start <= 1'b1;
            r_ren   <= ~d_wen;
            r_wen   <= d_wen;
            r_sign  <= d_sign;
            r_mask  <= d_mask;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_tlen  <= 8'd0;
            r_left  <= 8'd0;
            r_wd    <= '0;
          end
        end
        ST_OWN_I, ST_OWN_D: begin
          // A beat takes priority over a saturated watchdog.
          if (m_valid) begin
            r_wd <= '0;
            if (r_left == 8'd0) begin
              r_state  <= ST_IDLE;
              r_last_d <= w_own_d;
            end else begin
              r_left <= r_left - 8'd1;
            end
          end else if (w_wd_full) begin
            r_state  <= ST_IDLE;
            r_last_d <= w_own_d;
          end else begin
            r_wd <= r_wd + c_wd_one;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response routing follows the owner state with zero latency.
  assign i_ok    = m_valid & w_own_i;
  assign d_ok    = m_valid & w_own_d;
  assign i_err   = w_own_i & ~m_valid & w_wd_full;
  assign d_err   = w_own_d & ~m_valid & w_wd_full;
  assign i_rdata = w_own_i ? m_rdata : 32'd0;
  assign d_rdata = w_own_d ? m_rdata : 32'd0;

  assign gnt     = r_state;
  assign m_start = r_start;
  assign m_wen   = r_wen;
  assign m_ren   = r_ren;
  assign m_sign  = r_sign;
  assign m_mask  = r_mask;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_tlen  = r_tlen;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25040111_mem_arb
// Brief    : Directed + random bench for the memory-port arbiter, checked
//            each cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040111_mem_arb;

  localparam int TMO_W   = 4;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [7:0]  i_len = 8'd0;
  logic        i_ok;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic        d_sign = 1'b0;
  logic [1:0]  d_mask = 2'b00;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ok;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_start;
  logic        m_wen;
  logic        m_ren;
  logic        m_sign;
  logic [1:0]  m_mask;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  m_tlen;
  logic [31:0] m_rdata = 32'd0;
  logic        m_valid = 1'b0;
  logic [1:0]  gnt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ysyx_25040111_mem_arb #(.TMO_W(TMO_W)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
    .i_ok(i_ok), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wen(d_wen), .d_sign(d_sign), .d_mask(d_mask),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ok(d_ok), .d_rdata(d_rdata), .d_err(d_err),
    .m_start(m_start), .m_wen(m_wen), .m_ren(m_ren), .m_sign(m_sign),
    .m_mask(m_mask), .m_addr(m_addr), .m_wdata(m_wdata), .m_tlen(m_tlen),
    .m_rdata(m_rdata), .m_valid(m_valid), .gnt(gnt)
  );

  // Reference model: owner (0 none, 1 I, 2 D), last served side, beats
  // still expected, stall cycles since grant/beat, and the granted request.
  int          mo_owner;
  int          mo_last;
  int          mo_beats;
  int          mo_idle;
  bit          mo_start;
  logic        mo_ren, mo_wen, mo_sign;
  logic [1:0]  mo_mask;
  logic [31:0] mo_addr, mo_wdata;
  logic [7:0]  mo_tlen;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner = 0;
    mo_last  = 2;
    mo_beats = 0;
    mo_idle  = 0;
    mo_start = 1'b0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic sample();
    logic [1:0] eg;
    #1;
    eg = (mo_owner == 1) ? 2'b01 : (mo_owner == 2) ? 2'b10 : 2'b00;
    chk32("gnt", {30'd0, gnt}, {30'd0, eg});
    chk1("m_start", m_start, mo_start);
    chk1("i_ok", i_ok, m_valid && mo_owner == 1);
    chk1("d_ok", d_ok, m_valid && mo_owner == 2);
    chk1("i_err", i_err, !m_valid && mo_owner == 1 && mo_idle == TMO_MAX);
    chk1("d_err", d_err, !m_valid && mo_owner == 2 && mo_idle == TMO_MAX);
    chk32("i_rdata", i_rdata, (mo_owner == 1) ? m_rdata : 32'd0);
    chk32("d_rdata", d_rdata, (mo_owner == 2) ? m_rdata : 32'd0);
    if (mo_owner != 0) begin
      chk1("m_ren", m_ren, mo_ren);
      chk1("m_wen", m_wen, mo_wen);
      chk1("m_sign", m_sign, mo_sign);
      chk32("m_mask", {30'd0, m_mask}, {30'd0, mo_mask});
      chk32("m_addr", m_addr, mo_addr);
      chk32("m_tlen", {24'd0, m_tlen}, {24'd0, mo_tlen});
      if (mo_owner == 2) chk32("m_wdata", m_wdata, mo_wdata);
    end
  endtask

  // Advance the model by one clock from the current inputs, then clock.
  task automatic step();
    int pick;
    if (!reset) begin
      model_reset();
    end else if (mo_owner == 0) begin
      mo_start = 1'b0;
      pick = 0;
      if (i_req && d_req) pick = (mo_last == 2) ? 1 : 2;
      else if (i_req)     pick = 1;
      else if (d_req)     pick = 2;
      if (pick == 1) begin
        mo_owner = 1; mo_start = 1'b1; mo_idle = 0;
        mo_beats = int'(i_len) + 1;
        mo_ren = 1'b1; mo_wen = 1'b0; mo_sign = 1'b0; mo_mask = 2'b11;
        mo_addr = i_addr; mo_tlen = i_len;
      end else if (pick == 2) begin
        mo_owner = 2; mo_start = 1'b1; mo_idle = 0; mo_beats = 1;
        mo_ren = !d_wen; mo_wen = d_wen; mo_sign = d_sign; mo_mask = d_mask;
        mo_addr = d_addr; mo_wdata = d_wdata; mo_tlen = 8'd0;
      end
    end else begin
      mo_start = 1'b0;
      if (m_valid) begin
        mo_idle = 0;
        mo_beats--;
        if (mo_beats == 0) begin
          mo_last = mo_owner; mo_owner = 0;
        end
      end else if (mo_idle == TMO_MAX) begin
        mo_last = mo_owner; mo_owner = 0;
      end else begin
        mo_idle++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Return beats with short random gaps until the current owner finishes.
  task automatic drain();
    int gap;
    int c;
    gap = $urandom_range(0, 3);
    c = 0;
    while (mo_owner != 0 && c < 300) begin
      if (gap == 0) begin
        m_valid = 1'b1; m_rdata = $urandom; gap = $urandom_range(0, 3);
      end else begin
        m_valid = 1'b0; gap--;
      end
      sample();
      step();
      c++;
    end
    m_valid = 1'b0;
    chk1("drain_budget", mo_owner == 0, 1'b1);
  endtask

  initial begin
    int nok;
    int gap;
    int c;
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

    // Reset with both sides requesting and a stray beat present.
    model_reset();
    i_req = 1'b1; d_req = 1'b1; i_len = 8'd0; i_addr = $urandom;
    d_wen = 1'b0; d_sign = 1'($urandom); d_mask = 2'($urandom);
    d_addr = $urandom; d_wdata = $urandom;
    m_valid = 1'b1; m_rdata = $urandom;
    repeat (2) @(posedge clock);
    #1;
    sample();
    chk32("rst_m_addr", m_addr, 32'd0);
    chk32("rst_m_wdata", m_wdata, 32'd0);
    chk32("rst_m_tlen", {24'd0, m_tlen}, 32'd0);
    chk1("rst_m_ren", m_ren, 1'b0);
    chk1("rst_m_wen", m_wen, 1'b0);
    step();
    reset = 1'b1; m_valid = 1'b0;
    sample();
    step();

    // Tie alternation with single-beat responses: I, D, I, D.
    for (int k = 0; k < 4; k++) begin
      sample();
      chk32("tie_gnt", {30'd0, gnt}, {30'd0, seq[k]});
      chk1("tie_start", m_start, 1'b1);
      if (k == 0) begin
        chk32("first_m_addr", m_addr, i_addr);
        chk32("first_m_tlen", {24'd0, m_tlen}, {24'd0, i_len});
      end
      step();
      m_valid = 1'b1; m_rdata = $urandom;
      sample();
      step();
      m_valid = 1'b0;
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      sample();
      step();
    end

    // Eight-beat I burst; request dropped after grant.
    i_req = 1'b1; i_len = 8'd7; i_addr = 32'ha0000000;
    sample();
    step();
    sample();
    chk32("burst_gnt", {30'd0, gnt}, 32'd1);
    chk32("burst_tlen", {24'd0, m_tlen}, 32'd7);
    step();
    i_req = 1'b0;
    nok = 0;
    gap = $urandom_range(0, 3);
    c = 0;
    while (mo_owner != 0 && c < 200) begin
      if (gap == 0) begin
        m_valid = 1'b1; m_rdata = $urandom; gap = $urandom_range(0, 4);
      end else begin
        m_valid = 1'b0; gap--;
      end
      sample();
      if (i_ok === 1'b1) nok++;
      step();
      c++;
    end
    m_valid = 1'b0;
    chk32("burst_ok_count", nok, 32'd8);
    sample();
    chk32("burst_gnt_after", {30'd0, gnt}, 32'd0);
    step();

    // D store.
    d_req = 1'b1; d_wen = 1'b1; d_sign = 1'b0; d_mask = 2'b10;
    d_addr = 32'h80001000; d_wdata = 32'hdeadbeef;
    sample();
    step();
    sample();
    chk1("st_m_wen", m_wen, 1'b1);
    chk1("st_m_ren", m_ren, 1'b0);
    chk32("st_m_tlen", {24'd0, m_tlen}, 32'd0);
    chk32("st_m_wdata", m_wdata, 32'hdeadbeef);
    chk32("st_m_mask", {30'd0, m_mask}, 32'd2);
    step();
    d_req = 1'b0; m_valid = 1'b1; m_rdata = $urandom;
    sample();
    chk1("st_d_ok", d_ok, 1'b1);
    step();
    m_valid = 1'b0;
    sample();
    step();

    // D load.
    d_req = 1'b1; d_wen = 1'b0; d_sign = 1'b1; d_addr = $urandom;
    sample();
    step();
    sample();
    chk1("ld_m_ren", m_ren, 1'b1);
    chk1("ld_m_wen", m_wen, 1'b0);
    step();
    d_req = 1'b0; m_valid = 1'b1; m_rdata = $urandom;
    sample();
    chk1("ld_d_ok", d_ok, 1'b1);
    chk32("ld_d_rdata", d_rdata, m_rdata);
    chk32("ld_i_rdata", i_rdata, 32'd0);
    step();
    m_valid = 1'b0;
    sample();
    step();

    // Timeout, then a beat coinciding with saturation.
    for (int v = 0; v < 2; v++) begin
      d_req = 1'b1; d_wen = 1'b0; d_addr = $urandom;
      sample();
      step();
      d_req = 1'b0;
      sample();
      step();
      for (int k = 1; k < TMO_MAX; k++) begin
        sample();
        step();
      end
      m_valid = (v == 1); m_rdata = $urandom;
      sample();
      chk1("tmo_d_err", d_err, v == 0);
      chk1("tmo_d_ok", d_ok, v == 1);
      step();
      m_valid = 1'b0;
      sample();
      chk32("tmo_gnt_after", {30'd0, gnt}, 32'd0);
      step();
    end

    // Reset after 3 of 8 beats.
    i_req = 1'b1; i_len = 8'd7; i_addr = $urandom;
    sample();
    step();
    i_req = 1'b0;
    sample();
    step();
    for (int k = 0; k < 3; k++) begin
      m_valid = 1'b1; m_rdata = $urandom;
      sample();
      step();
      m_valid = 1'b0;
      sample();
      step();
    end
    m_valid = 1'b1;
    reset = 1'b0;
    model_reset();
    sample();
    chk32("rst_mid_gnt", {30'd0, gnt}, 32'd0);
    chk1("rst_mid_i_ok", i_ok, 1'b0);
    chk32("rst_mid_m_addr", m_addr, 32'd0);
    chk32("rst_mid_m_tlen", {24'd0, m_tlen}, 32'd0);
    step();
    reset = 1'b1;
    sample();
    chk1("stray_i_ok", i_ok, 1'b0);
    step();
    m_valid = 1'b0;
    sample();
    chk32("stray_gnt", {30'd0, gnt}, 32'd0);
    i_req = 1'b1; i_len = 8'($urandom_range(0, 3)); i_addr = $urandom;
    step();
    sample();
    chk1("regrant_start", m_start, 1'b1);
    chk32("regrant_addr", m_addr, i_addr);
    step();
    i_req = 1'b0;
    drain();

    // Random traffic in segments of varying beat density.
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 150; n++) begin
        i_req = 1'($urandom); d_req = 1'($urandom);
        i_addr = $urandom; i_len = 8'($urandom_range(0, 7));
        d_wen = 1'($urandom); d_sign = 1'($urandom); d_mask = 2'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
        m_valid = (seg == 2) ? ($urandom_range(0, 19) == 0)
                             : ($urandom_range(0, seg + 1) == 0);
        m_rdata = $urandom;
        sample();
        step();
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25040111_mem_arb.md
# ysyx_25040111_mem_arb

Two-requester arbiter and sequencer for the core's single load/store memory port. It shares the LSU/AXI master between the instruction-cache refill path (I) and the data load/store path (D), and replaces the inline if_flag mux in the core top. It grants one requester at a time and issues a one-cycle start pulse with registered, stable request fields. It counts read beats for I-side bursts and routes each response beat back to the owner. A watchdog aborts transactions that never complete.

## Interface
- TMO_W, 8: width of the watchdog counter; timeout fires after 2^TMO_W−1 idle cycles.
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  I-side request (level); held until i_ok final beat or i_err.
- i_addr  in  32  I-side refill base address.
- i_len  in  8  I-side burst length minus 1 (beats = i_len+1).
- i_ok  out  1  one pulse per returned I beat.
- i_rdata  out  32  I beat data, valid with i_ok.
- i_err  out  1  one-cycle pulse on I timeout.
- d_req  in  1  D-side request (level).
- d_wen  in  1  1 = store, 0 = load.
- d_sign  in  1  sign-extend load.
- d_mask  in  2  access size (as opt[11:10]).
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ok  out  1  D completion pulse.
- d_rdata  out  32  load data, valid with d_ok.
- d_err  out  1  one-cycle pulse on D timeout.
- m_start  out  1  one-cycle start to LSU (LSU ready).
- m_wen, m_ren, m_sign  out  1 each  registered access controls.
- m_mask  out  2  registered access size.
- m_addr, m_wdata  out  32 each  registered address/data.
- m_tlen  out  8  registered burst length minus 1.
- m_rdata  in  32  LSU read data.
- m_valid  in  1  LSU beat/completion pulse.
- gnt  out  2  one-hot owner: [0]=I, [1]=D; 00 when idle.

## Operation
- FSM states: IDLE, OWN_I, OWN_D.
- IDLE with one request asserted moves to that requester's state.
- IDLE with both requests asserted uses a round-robin pointer `last`; the requester not served last wins.
- After reset, `last` = D, so I wins the first tie.
- On grant, the registered m_* fields are loaded and held until return to IDLE.
  - I grant: m_ren=1, m_wen=0, m_sign=0, m_mask=11, m_tlen=i_len.
  - D grant: m_ren=~d_wen, m_wen=d_wen, m_tlen=0; other fields copied from the D inputs.
- m_start pulses exactly once, in the first cycle of OWN_x.
- Beat counter `left` is loaded with m_tlen at grant and decremented on each m_valid.
- m_valid when left≠0 is a non-final beat.
- m_valid when left=0 is the final beat: the FSM goes to IDLE and `last` updates to the owner.
- Response routing is combinational from the owner state:
  - i_ok = m_valid & OWN_I; d_ok = m_valid & OWN_D.
  - Owner rdata = m_rdata; the non-owner's rdata = 0.
- Watchdog: cleared at grant and on every m_valid, otherwise incremented. At all-ones:
  - pulse x_err for the owner (x_ok stays 0);
  - return to IDLE; `last` updates to the owner.
- m_valid seen in IDLE is ignored: no ok pulse and no state change.
- A requester deasserting x_req mid-transaction is ignored; the transaction completes and responses are still forwarded.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, gnt=00, m_start=0, all m_* = 0, left=0, watchdog=0, `last`=D.
  - Combinational i_ok/d_ok/i_err/d_err are 0, and i_rdata/d_rdata are 0, because no owner exists.
- Reset mid-transaction abandons it without any ok/err pulse.
- Request latency: x_req high in IDLE at edge N → gnt and m_start high in cycle N+1.
- Response latency: zero; x_ok is in the same cycle as m_valid.
- Turnaround: final m_valid in cycle M → IDLE in M+1 → next grant and m_start in M+2 at the earliest.
- A request is sampled only in IDLE; a requester raising x_req during another's transaction waits.
- m_* outputs are stable from m_start until the cycle after the final beat.
- Burst of L+1 beats produces exactly L+1 i_ok pulses; beats may be non-consecutive.
- A timeout fires 2^TMO_W−1 cycles after the last grant or beat, counted with no m_valid.
- If m_valid and watchdog saturation coincide, m_valid wins: the beat is delivered and the watchdog clears.

## Test plan
- Reset with i_req=d_req=1 held; release reset → I granted first: gnt=01, m_start pulse, m_addr=i_addr, m_tlen=i_len.
- I burst: i_len=7, i_addr=0xa0000000; LSU returns 8 beats with random gaps → exactly 8 i_ok pulses with matching data, then gnt=00 one cycle later.
- Tie alternation: both requests held permanently with 1-beat responses → grants alternate I, D, I, D; d_ok never asserts while gnt=01.
- D store then load: d_wen=1, d_addr=0x80001000, d_wdata=0xdeadbeef, d_mask=10 → m_wen=1, m_ren=0, m_tlen=0. Then a load → m_ren=1 and d_rdata=m_rdata on d_ok.
- Timeout: TMO_W=4, D granted, no m_valid → d_err pulses 15 cycles after grant, then gnt=00. A coincident m_valid in the 15th cycle gives d_ok instead.
- Reset asserted mid-burst, after 3 of 8 beats → outputs zero immediately; after release, a fresh i_req gets a new m_start, and stray m_valid in IDLE is ignored.
